// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: field widths, NOP encoding, hazard FSM states.
package mips_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned MD_LAT_DEF = 4;
  localparam int unsigned PERF_W     = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } ctrl_state_t;

endpackage : mips_pkg

// File: rtl/md_busy_tracker.sv
// Mult/div occupancy tracker: holds MD_BUSY for MD_LAT cycles after each issue.
module md_busy_tracker #(
  parameter int unsigned MD_LAT = mips_pkg::MD_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic md_busy
);

  import mips_pkg::*;

  localparam int unsigned MD_CNT_W = $clog2(MD_LAT + 1);

  ctrl_state_t         state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

  // State and busy-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next state: load the occupancy on issue, count down to release.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_CNT_W'(MD_LAT);
        end
      end
      MD_BUSY: begin
        if (md_cnt_q == MD_CNT_W'(1)) begin
          state_d  = IDLE;
          md_cnt_d = '0;
        end else begin
          md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        end
      end
    endcase
  end

  // Busy flag decoded straight from the state.
  always_comb begin
    md_busy = (state_q == MD_BUSY);
  end

endmodule : md_busy_tracker

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS32 pipeline.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W  = mips_pkg::REG_W,
  parameter int unsigned MD_LAT = mips_pkg::MD_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_muldiv,
  input  logic             id_reads_hilo,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  import mips_pkg::*;

  logic load_use;
  logic md_hazard;
  logic issue;

  // Hazard conditions; $0 is hardwired so it never creates a dependency.
  always_comb begin
    load_use  = ex_mem_read && (ex_rt != '0) &&
                ((id_uses_rs && (id_rs == ex_rt)) ||
                 (id_uses_rt && (id_rt == ex_rt)));
    md_hazard = md_busy && (id_is_muldiv || id_reads_hilo);
    issue     = id_is_muldiv && !ex_branch_taken && !load_use && !md_hazard;
  end

  // Priority mux of the pipeline strobes: reset > branch > stall > normal.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst_n) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use || md_hazard) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  md_busy_tracker #(
    .MD_LAT (MD_LAT)
  ) u_md_busy_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (issue),
    .md_busy (md_busy)
  );

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating increments for bubble-only stalls and flushes.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (idex_bubble && !ifid_flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
    if (ifid_flush && rst_n && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + PERF_W'(1);
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MD_LAT = 4).
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_W = 5;

  // Strobe vectors {pc_we, ifid_we, ifid_flush, idex_bubble, md_busy}.
  localparam logic [4:0] S_RESET   = 5'b00110;
  localparam logic [4:0] S_NORMAL  = 5'b11000;
  localparam logic [4:0] S_NORM_MD = 5'b11001;
  localparam logic [4:0] S_BRANCH  = 5'b11110;
  localparam logic [4:0] S_BR_MD   = 5'b11111;
  localparam logic [4:0] S_STALL   = 5'b00010;
  localparam logic [4:0] S_STL_MD  = 5'b00011;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             id_uses_rs, id_uses_rt, id_is_muldiv, id_reads_hilo;
  logic             ex_mem_read, ex_branch_taken;
  logic             pc_we, ifid_we, ifid_flush, idex_bubble, md_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]      perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(
    .REG_W  (REG_W),
    .MD_LAT (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_is_muldiv    (id_is_muldiv),
    .id_reads_hilo   (id_reads_hilo),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .md_busy         (md_busy)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_muldiv = 1'b0; id_reads_hilo = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] exp_v);
    logic [31:0] obs_v;
    #1;
    obs_v = {27'd0, pc_we, ifid_we, ifid_flush, idex_bubble, md_busy};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%05b expected=%05b", tag, obs_v[4:0], exp_v[4:0]);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs_v, exp_v);
    end
  endtask

  task automatic load_use_in();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    #12;
    chk("reset", S_RESET);
    rst_n = 1'b1;
    chk("post_reset_normal", S_NORMAL);

    // Load-use on rs: one stall, then the load has left EX.
    tick(); load_use_in();
    chk("load_use_rs", S_STALL);
    tick(); clear_in();
    chk("load_use_released", S_NORMAL);

    // Load-use on rt, and rt not used.
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
    chk("load_use_rt", S_STALL);
    id_uses_rt = 1'b0;
    chk("rt_not_used", S_NORMAL);

    // $0 never stalls.
    tick(); clear_in();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    chk("load_use_r0", S_NORMAL);

    // Taken branch beats a load-use.
    tick(); clear_in(); load_use_in(); ex_branch_taken = 1'b1;
    chk("branch_over_load_use", S_BRANCH);

    // Flushed mult/div does not issue.
    tick(); clear_in(); id_is_muldiv = 1'b1; ex_branch_taken = 1'b1;
    chk("muldiv_flushed", S_BRANCH);
    tick(); clear_in();
    chk("muldiv_flushed_no_busy", S_NORMAL);

    // Stalled mult/div does not issue.
    tick(); load_use_in(); id_is_muldiv = 1'b1;
    chk("muldiv_stalled", S_STALL);
    tick(); clear_in();
    chk("muldiv_stalled_no_busy", S_NORMAL);

    // MULT then MFLO: four stall cycles, MFLO goes on the fifth.
    tick(); id_is_muldiv = 1'b1;
    chk("mult_issue", S_NORMAL);
    tick(); clear_in(); id_reads_hilo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mflo_stall_%0d", i), S_STL_MD);
      tick();
    end
    chk("mflo_advance", S_NORMAL);

    // Busy with independent instruction, branch mid-occupancy keeps the count.
    clear_in(); id_is_muldiv = 1'b1;
    chk("mult2_issue", S_NORMAL);
    tick(); clear_in();
    chk("busy_indep", S_NORM_MD);
    tick(); ex_branch_taken = 1'b1;
    chk("busy_branch", S_BR_MD);
    tick(); clear_in();
    chk("busy_c3", S_NORM_MD);
    tick();
    chk("busy_c4", S_NORM_MD);
    tick();
    chk("busy_done", S_NORMAL);

    // Back-to-back mult/div: stall until idle, issue on first idle cycle.
    id_is_muldiv = 1'b1;
    chk("b2b_first_issue", S_NORMAL);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("b2b_stall_%0d", i), S_STL_MD);
    end
    tick();
    chk("b2b_second_issue", S_NORMAL);
    tick(); clear_in();
    chk("b2b_busy_again", S_NORM_MD);
    tick();
    chk("b2b_busy_cnt3", S_NORM_MD);

    // Asynchronous reset in the middle of an occupancy.
    #2 rst_n = 1'b0;
    chk("reset_mid_busy", S_RESET);
    #2 rst_n = 1'b1;
    chk("reset_release", S_NORMAL);
    tick();
    chk("reset_stays_idle", S_NORMAL);

`ifdef HAZ_PERF_CNT_EN
    // Three bubble-only stalls and two flushes from a clean reset.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    chk_val("perf_stall_reset", perf_stall_cnt, 32'd0);
    chk_val("perf_flush_reset", perf_flush_cnt, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); load_use_in();
      tick(); clear_in();
    end
    for (int i = 0; i < 2; i++) begin
      tick(); ex_branch_taken = 1'b1;
      tick(); clear_in();
    end
    tick();
    chk_val("perf_stall_cnt", perf_stall_cnt, 32'd3);
    chk_val("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
